level_driver: RTL and testbench

LEVEL_DRIVER -- requirements
Module: level_driver

---
 rtl/level_driver.sv | 119 +++++++++++
 tb/tb_level_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/level_driver.sv
// Rate-limited level output: requested levels are queued in a small FIFO and
// applied to `out` no more often than once every DUR clock edges.
module level_driver #(
  parameter int   FREQ  = 25_000_000,
  parameter int   LIMIT = 50_000,
  parameter int   DUR   = FREQ / LIMIT,
  parameter int   N     = 14,
  parameter int   DEPTH = 4,
  parameter logic INIT  = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr,
  input  logic                     wr_level,
  output logic                     ready,
  output logic                     out,
  output logic                     strobe,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     state_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [N:0]  LOAD      = (N+1)'(DUR - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [0:0]       state_q, state_d;
  logic [N:0]       cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             strobe_q, strobe_d;
  logic             overflow_q;
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q, count_d;

  logic push, pop, eligible, head;

  // ready looks only at the registered count, so a pop in the same cycle
  // never lets a write into a full FIFO.
  assign ready    = (count_q < DEPTH_CNT);
  assign push     = wr && ready;
  assign eligible = (state_q == IDLE) || (cnt_q == '0);
  assign pop      = eligible && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    if (pop) begin
      // A popped level equal to the current output is discarded silently.
      if (head != out_q) begin
        out_d    = ~out_q;
        strobe_d = 1'b1;
        cnt_d    = LOAD;
        state_d  = HOLD;
      end
    end else if (state_q == HOLD) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_q      <= INIT;
      strobe_q   <= 1'b0;
      overflow_q <= 1'b0;
      mem_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      count_q  <= count_d;
      if (wr && !ready) begin
        overflow_q <= 1'b1;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= wr_level;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign out      = out_q;
  assign strobe   = strobe_q;
  assign busy     = (state_q == HOLD) || (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_level_driver.sv
// Directed bench for level_driver with DUR=4, DEPTH=4: vector table plus a
// hand-written asynchronous-reset-during-hold sequence.
module tb_level_driver;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr = 1'b0;
  logic       wr_level = 1'b0;
  logic       ready, out, strobe, busy, overflow, state_o;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  level_driver #(
    .FREQ(8), .LIMIT(2), .DEPTH(4), .INIT(1'b0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .wr(wr), .wr_level(wr_level),
    .ready(ready), .out(out), .strobe(strobe), .busy(busy),
    .count(count), .overflow(overflow), .state_o(state_o)
  );

  // clock / reset
  always #5 clock = ~clock;

  // packed observation: {out, strobe, count[2:0], busy, ready, overflow}
  typedef struct {
    logic       rst;
    logic       wr;
    logic       lvl;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  function automatic logic [7:0] pk(input logic o, input logic s, input int c,
                                    input logic b, input logic r, input logic ov);
    logic [2:0] c3;
    c3 = 3'(c);
    return {o, s, c3, b, r, ov};
  endfunction

  function automatic logic [7:0] obs();
    return {out, strobe, count, busy, ready, overflow};
  endfunction

  task automatic add(input logic rst, input logic w, input logic l, input logic [7:0] e);
    vec_t v;
    v.rst = rst; v.wr = w; v.lvl = l; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [7:0] e);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    wr = 1'b0;
    wr_level = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    check("reset_state", obs(), pk(0, 0, 0, 0, 1, 0));
    reset_n = 1'b1;
  endtask

  initial begin
    // single rising request
    add(1, 0, 0, pk(0, 0, 0, 0, 1, 0));
    add(0, 0, 0, pk(0, 0, 0, 0, 1, 0));
    add(0, 1, 1, pk(0, 0, 1, 1, 1, 0));
    add(0, 0, 0, pk(1, 1, 0, 1, 1, 0));
    add_n(3, pk(1, 0, 0, 1, 1, 0));
    add_n(2, pk(1, 0, 0, 0, 1, 0));
    // back-to-back differing levels 1,0,1
    add(1, 0, 0, pk(0, 0, 0, 0, 1, 0));
    add(0, 1, 1, pk(0, 0, 1, 1, 1, 0));
    add(0, 1, 0, pk(1, 1, 1, 1, 1, 0));
    add(0, 1, 1, pk(1, 0, 2, 1, 1, 0));
    add_n(2, pk(1, 0, 2, 1, 1, 0));
    add(0, 0, 0, pk(0, 1, 1, 1, 1, 0));
    add_n(3, pk(0, 0, 1, 1, 1, 0));
    add(0, 0, 0, pk(1, 1, 0, 1, 1, 0));
    add_n(3, pk(1, 0, 0, 1, 1, 0));
    add(0, 0, 0, pk(1, 0, 0, 0, 1, 0));
    // same-level requests are discarded
    add(1, 0, 0, pk(0, 0, 0, 0, 1, 0));
    add(0, 1, 0, pk(0, 0, 1, 1, 1, 0));
    add(0, 1, 0, pk(0, 0, 1, 1, 1, 0));
    add_n(2, pk(0, 0, 0, 0, 1, 0));
    // fill during hold, overflow on full (with and without a same-cycle pop)
    add(1, 0, 0, pk(0, 0, 0, 0, 1, 0));
    add(0, 1, 1, pk(0, 0, 1, 1, 1, 0));
    add(0, 1, 0, pk(1, 1, 1, 1, 1, 0));
    add(0, 1, 1, pk(1, 0, 2, 1, 1, 0));
    add(0, 1, 0, pk(1, 0, 3, 1, 1, 0));
    add(0, 1, 1, pk(1, 0, 4, 1, 0, 0));
    add(0, 1, 1, pk(0, 1, 3, 1, 1, 1));
    add(0, 1, 0, pk(0, 0, 4, 1, 0, 1));
    add(0, 1, 1, pk(0, 0, 4, 1, 0, 1));
    add(0, 0, 0, pk(0, 0, 4, 1, 0, 1));
    add(0, 0, 0, pk(1, 1, 3, 1, 1, 1));
    add_n(3, pk(1, 0, 3, 1, 1, 1));
    add(0, 0, 0, pk(0, 1, 2, 1, 1, 1));
    add_n(3, pk(0, 0, 2, 1, 1, 1));
    add(0, 0, 0, pk(1, 1, 1, 1, 1, 1));
    add_n(3, pk(1, 0, 1, 1, 1, 1));
    add(0, 0, 0, pk(0, 1, 0, 1, 1, 1));
    add_n(3, pk(0, 0, 0, 1, 1, 1));
    add_n(2, pk(0, 0, 0, 0, 1, 1));

    step();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) apply_reset();
      wr = vecs[i].wr;
      wr_level = vecs[i].lvl;
      exp_q.push_back(vecs[i].exp);
      step();
      wr = 1'b0;
      check($sformatf("vec%0d", i), obs(), exp_q.pop_front());
    end

    // asynchronous reset between edges in the middle of a hold
    apply_reset();
    wr = 1'b1; wr_level = 1'b1; step();
    wr = 1'b1; wr_level = 1'b0; step();
    wr = 1'b1; wr_level = 1'b1; step();
    wr = 1'b0;
    check("pre_reset", {obs(), 1'b0, state_o}, {pk(1, 0, 2, 1, 1, 0), 1'b0, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", {obs(), 1'b0, state_o}, {pk(0, 0, 0, 0, 1, 0), 1'b0, 1'b0});
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("post_reset%0d", i), obs(), pk(0, 0, 0, 0, 1, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
